// File: rtl/pdm_decimator.sv
// Third-order CIC decimator: 1-bit PDM stream in, unsigned NBITS amplitude samples out.
// Integrators run at the bit rate, combs run once per R valid bits, and the result is saturated to NBITS.
module pdm_decimator #(
   parameter int NBITS  = 16,
   parameter int LOG2_R = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   output logic [NBITS-1:0] dout,
   output logic             out_valid,
   output logic             clipped
);

   localparam int W     = 1 + 3 * LOG2_R;
   localparam int SHIFT = W - 1 - NBITS;

   logic [W-1:0]      i1, i2, i3;
   logic [W-1:0]      i1_nx, i2_nx, i3_nx;
   logic [LOG2_R-1:0] cnt;
   logic [1:0]        settle;
   logic              evt;

   logic [W-1:0]      x_p0;
   logic              vld_p0;
   logic              emit_p0;

   logic [W-1:0]      d1, d2, d3;
   logic [W-1:0]      c1, c2, c3;

   function automatic logic [NBITS-1:0] sat_sample(input logic [W-1:0] y);
      logic [W-1:0] s;
      s = y >> SHIFT;
      return (|s[W-1:NBITS]) ? {NBITS{1'b1}} : s[NBITS-1:0];
   endfunction

   function automatic logic is_clipped(input logic [W-1:0] y);
      logic [W-1:0] s;
      s = y >> SHIFT;
      return |s[W-1:NBITS];
   endfunction

   // Integrator sums wrap modulo 2^W on purpose; the combs cancel the wrap exactly.
   assign i1_nx = i1 + {{(W-1){1'b0}}, din};
   assign i2_nx = i2 + i1_nx;
   assign i3_nx = i3 + i2_nx;
   assign evt   = din_valid && (cnt == {LOG2_R{1'b1}});

   assign c1 = x_p0 - d1;
   assign c2 = c1 - d2;
   assign c3 = c2 - d3;

   always_ff @(posedge clock) begin
      if (!reset) begin
         i1        <= '0;
         i2        <= '0;
         i3        <= '0;
         cnt       <= '0;
         settle    <= '0;
         x_p0      <= '0;
         vld_p0    <= 1'b0;
         emit_p0   <= 1'b0;
         d1        <= '0;
         d2        <= '0;
         d3        <= '0;
         dout      <= '0;
         clipped   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (din_valid) begin
            i1  <= i1_nx;
            i2  <= i2_nx;
            i3  <= i3_nx;
            cnt <= cnt + 1'b1;
         end

         // p0: capture the decimated integrator value; the first three events only prime the combs
         vld_p0 <= evt;
         if (evt) begin
            x_p0    <= i3_nx;
            emit_p0 <= (settle == 2'd3);
            if (settle != 2'd3)
               settle <= settle + 2'd1;
         end

         // p1: comb chain, delays advance once per decimated sample
         out_valid <= vld_p0 && emit_p0;
         if (vld_p0) begin
            d1 <= x_p0;
            d2 <= c1;
            d3 <= c2;
            if (emit_p0) begin
               dout    <= sat_sample(c3);
               clipped <= is_clipped(c3);
            end
         end
      end
   end

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator: constant, alternating, gapped and sigma-delta PDM
// streams, plus a mid-window reset. Expected samples are derived by hand.
module tb_pdm_decimator;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic [15:0] dout;
   logic        out_valid;
   logic        clipped;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int c0 = 0;

   typedef struct {
      int d;
      int c;
      int t;
   } strobe_t;
   strobe_t q[$];

   logic [16:0] sd_acc;

   pdm_decimator #(.NBITS(16), .LOG2_R(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .din      (din),
      .din_valid(din_valid),
      .dout     (dout),
      .out_valid(out_valid),
      .clipped  (clipped)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock)
      if (out_valid === 1'b1)
         q.push_back('{int'(dout), int'(clipped), cyc});

   task automatic check(input string tag, input integer got, input integer exp, input integer tol = 0);
      integer diff;
      checks++;
      diff = got - exp;
      if (diff < 0) diff = -diff;
      if ($isunknown(got) || diff > tol) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (tol %0d)", tag, got, exp, tol);
      end
   endtask

   // Holds reset low across one rising edge; din/din_valid are left as the caller set them.
   task automatic pulse_reset();
      reset = 1'b0;
      @(posedge clock);
      #1;
      c0 = cyc;
      reset = 1'b1;
      q.delete();
   endtask

   // mode 0: constant din=val[0]; 1: alternating 1,0; 2: din=1 with valid toggling; 3: sigma-delta of val
   task automatic run(input int n, input int mode, input logic [15:0] val);
      sd_acc = '0;
      for (int i = 0; i < n; i++) begin
         din_valid = 1'b1;
         case (mode)
            0: din = val[0];
            1: din = (i % 2 == 0);
            2: begin din = 1'b1; din_valid = (i % 2 == 0); end
            default: begin
               sd_acc = {1'b0, sd_acc[15:0]} + {1'b0, val};
               din = sd_acc[16];
            end
         endcase
         @(posedge clock);
         #1;
      end
      din_valid = 1'b0;
      din = 1'b0;
   endtask

   task automatic check_strobes(input string tag, input int n_exp, input int first, input int spacing,
                                input int val, input int clip, input int tol);
      check({tag, "_count"}, q.size(), n_exp);
      if (q.size() > 0)
         check({tag, "_first_clk"}, q[0].t - c0, first);
      for (int k = 0; k < q.size(); k++) begin
         check($sformatf("%s_dout%0d", tag, k), q[k].d, val, tol);
         check($sformatf("%s_clip%0d", tag, k), q[k].c, clip);
         if (k > 0)
            check($sformatf("%s_gap%0d", tag, k), q[k].t - q[k-1].t, spacing);
      end
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_dout", dout, 0);
      check("rst_valid", out_valid, 0);
      check("rst_clip", clipped, 0);

      // all ones: clips from the 4th event; first strobe at clock 1025
      pulse_reset();
      run(1794, 0, 16'h0001);
      check_strobes("ones", 4, 1025, 256, 16'hFFFF, 1, 0);

      // all zeros
      pulse_reset();
      run(1794, 0, 16'h0000);
      check_strobes("zeros", 4, 1025, 256, 0, 0, 0);

      // alternating 1,0 gives exactly half scale
      pulse_reset();
      run(1794, 1, 16'h0000);
      check_strobes("alt", 4, 1025, 256, 16'h8000, 0, 0);

      // gaps in din_valid are transparent, including the cycle after each event
      pulse_reset();
      run(3586, 2, 16'h0000);
      check_strobes("gapped", 4, 2048, 512, 16'hFFFF, 1, 0);

      // first-order sigma-delta loopback
      pulse_reset();
      run(1794, 3, 16'h4000);
      check_strobes("loop4000", 4, 1025, 256, 16'h4000, 0, 2);
      pulse_reset();
      run(1794, 3, 16'hC000);
      check_strobes("loopC000", 4, 1025, 256, 16'hC000, 0, 2);

      // integrators wrap many times before the reset; outputs must stay exact
      pulse_reset();
      run(9 * 256 + 99, 0, 16'h0001);
      check_strobes("prewrap", 6, 1025, 256, 16'hFFFF, 1, 0);
      check("pre_rst_dout", dout, 16'hFFFF);

      // reset at bit 100 of window 10 with din_valid high: reset must win
      din = 1'b1;
      din_valid = 1'b1;
      pulse_reset();
      din_valid = 1'b0;
      check("mid_rst_dout", dout, 0);
      check("mid_rst_clip", clipped, 0);
      check("mid_rst_valid", out_valid, 0);
      run(20 * 256 + 2, 0, 16'h0001);
      check_strobes("postrst", 17, 1025, 256, 16'hFFFF, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
